// File: rtl/bpm_pkg.sv
// Shared types and constants for the BPM peak-detect slice.
// Optional PEAK_OVERRANGE_EN adds the per-channel overrange flags.
package bpm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ACQ,
    ST_FLUSH,
    ST_DONE
  } peak_state_t;

  localparam int ADC_W_DEF     = 14;
  localparam int OUT_W_DEF     = 16;
  localparam int PEAK_PIPE_LAT = 2;

endpackage

// File: rtl/peak_channel.sv
// One channel: sample capture, |x| stage, running-max stage.
// PEAK_OVERRANGE_EN adds the full-scale flag output.
module peak_channel
  import bpm_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             accept,
  input  logic [ADC_W-1:0] adc,
`ifdef PEAK_OVERRANGE_EN
  output logic             ovr,
`endif
  output logic [OUT_W-1:0] peak
);

  logic             sv_q;
  logic [ADC_W-1:0] x_q;
  logic             av_q;
  logic [ADC_W:0]   abs_q;
  logic [ADC_W:0]   peak_q;
  logic signed [ADC_W:0] xs;
  logic [ADC_W:0]   mag;

  // One extra bit so |-2^(ADC_W-1)| does not wrap
  always_comb begin
    xs  = {x_q[ADC_W-1], x_q};
    mag = xs;
    if (xs[ADC_W]) mag = -xs;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sv_q   <= 1'b0;
      x_q    <= '0;
      av_q   <= 1'b0;
      abs_q  <= '0;
      peak_q <= '0;
    end else begin
      sv_q <= accept;
      if (accept) x_q <= adc;
      av_q  <= sv_q;
      abs_q <= mag;
      if (av_q && (abs_q > peak_q)) peak_q <= abs_q;
    end
  end

  assign peak = OUT_W'(peak_q);

`ifdef PEAK_OVERRANGE_EN
  localparam logic [ADC_W-1:0] MAXP = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [ADC_W-1:0] MINN = {1'b1, {(ADC_W-1){1'b0}}};

  logic or_q;
  logic ovr_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      or_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      or_q <= (x_q == MAXP) || (x_q == MINN);
      if (av_q && or_q) ovr_q <= 1'b1;
    end
  end

  assign ovr = ovr_q;
`endif

endmodule

// File: rtl/peak_detect.sv
// Four-channel triggered peak detector: FSM, delay/window counters.
// PEAK_OVERRANGE_EN adds the 4-bit overrange output.
module peak_detect
  import bpm_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [15:0]      trig_delay,
  input  logic [15:0]      win_len,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] adc_a,
  input  logic [ADC_W-1:0] adc_b,
  input  logic [ADC_W-1:0] adc_c,
  input  logic [ADC_W-1:0] adc_d,
  output logic [OUT_W-1:0] signal_max_a,
  output logic [OUT_W-1:0] signal_max_b,
  output logic [OUT_W-1:0] signal_max_c,
  output logic [OUT_W-1:0] signal_max_d,
`ifdef PEAK_OVERRANGE_EN
  output logic [3:0]       overrange,
`endif
  output logic             ready,
  output logic             busy
);

  localparam logic [1:0] FL_LAST = 2'(PEAK_PIPE_LAT - 1);

  peak_state_t state_q;
  logic [15:0] dly_q;
  logic [15:0] rem_q;
  logic [1:0]  fl_q;
  logic        ready_q;
  logic        busy_q;

  logic arm;
  logic acq_entry;
  logic accept;

  always_comb begin
    arm = trigger &&
          ((state_q == ST_IDLE) || (state_q == ST_DONE));
    acq_entry = (arm && (trig_delay == 16'd0)) ||
                ((state_q == ST_DELAY) && sample_valid &&
                 (dly_q == 16'd1));
    accept = (state_q == ST_ACQ) && sample_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      rem_q   <= '0;
      fl_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (acq_entry) ready_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (trigger) begin
            busy_q  <= 1'b1;
            dly_q   <= trig_delay;
            rem_q   <= (win_len == 16'd0) ? 16'd1 : win_len;
            state_q <= (trig_delay == 16'd0) ? ST_ACQ : ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (sample_valid) begin
            dly_q <= dly_q - 16'd1;
            if (dly_q == 16'd1) state_q <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (sample_valid) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= ST_FLUSH;
              fl_q    <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (fl_q == FL_LAST) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            fl_q <= fl_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;

  logic [ADC_W-1:0] adc_s [4];
  logic [OUT_W-1:0] max_s [4];

  assign adc_s[0] = adc_a;
  assign adc_s[1] = adc_b;
  assign adc_s[2] = adc_c;
  assign adc_s[3] = adc_d;

`ifdef PEAK_OVERRANGE_EN
  logic [3:0] ovr_s;
  assign overrange = ovr_s;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_ch
    peak_channel #(
      .ADC_W(ADC_W),
      .OUT_W(OUT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .clear (acq_entry),
      .accept(accept),
      .adc   (adc_s[i]),
`ifdef PEAK_OVERRANGE_EN
      .ovr   (ovr_s[i]),
`endif
      .peak  (max_s[i])
    );
  end

  assign signal_max_a = max_s[0];
  assign signal_max_b = max_s[1];
  assign signal_max_c = max_s[2];
  assign signal_max_d = max_s[3];

endmodule

// File: tb/tb_peak_detect.sv
// Bench for peak_detect: timestamped behavioural model plus literal checks.
// Build with PEAK_OVERRANGE_EN to also cover the overrange port.
module tb_peak_detect;

  localparam int AW = 14;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trigger = 1'b0;
  logic [15:0]   trig_delay = '0;
  logic [15:0]   win_len = '0;
  logic          sample_valid = 1'b0;
  logic [AW-1:0] adc_a = '0, adc_b = '0, adc_c = '0, adc_d = '0;
  logic [OW-1:0] signal_max_a, signal_max_b, signal_max_c, signal_max_d;
  logic          ready, busy;
`ifdef PEAK_OVERRANGE_EN
  logic [3:0]    overrange;
`endif

  peak_detect #(.ADC_W(AW), .OUT_W(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .trig_delay  (trig_delay),
    .win_len     (win_len),
    .sample_valid(sample_valid),
    .adc_a       (adc_a),
    .adc_b       (adc_b),
    .adc_c       (adc_c),
    .adc_d       (adc_d),
    .signal_max_a(signal_max_a),
    .signal_max_b(signal_max_b),
    .signal_max_c(signal_max_c),
    .signal_max_d(signal_max_d),
`ifdef PEAK_OVERRANGE_EN
    .overrange   (overrange),
`endif
    .ready       (ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_DELAY = 1, P_ACQ = 2, P_FLUSH = 3, P_DONE = 4;

  typedef struct packed {
    int          t;
    logic [3:0]  o;
    logic [63:0] v;
  } ev_t;

  ev_t  evq[$];
  int   m_peak[4];
  logic [3:0] m_ovr;
  bit   m_ready, m_busy;
  int   m_phase, m_d, m_n, m_done_at, cyc;

  function automatic int mag(logic [AW-1:0] x);
    int s;
    s = int'($signed(x));
    return (s < 0) ? -s : s;
  endfunction

  function automatic bit fs(logic [AW-1:0] x);
    int s;
    s = int'($signed(x));
    return (s == 8191) || (s == -8192);
  endfunction

  task automatic m_enter_acq();
    for (int i = 0; i < 4; i++) m_peak[i] = 0;
    m_ovr   = '0;
    m_ready = 0;
    m_phase = P_ACQ;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_peak[i] = 0;
    m_ovr = '0; m_ready = 0; m_busy = 0; m_phase = P_IDLE;
    m_d = 0; m_n = 0; m_done_at = -1; cyc = 0;
  end

  always @(posedge clk) begin
    ev_t e;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_peak[i] = 0;
      m_ovr = '0; m_ready = 0; m_busy = 0; m_phase = P_IDLE;
      evq.delete();
    end else begin
      if ((m_phase == P_IDLE || m_phase == P_DONE) && trigger) begin
        m_busy = 1;
        m_d = int'(trig_delay);
        m_n = (win_len == 0) ? 1 : int'(win_len);
        if (m_d == 0) m_enter_acq();
        else m_phase = P_DELAY;
      end else if (m_phase == P_DELAY && sample_valid) begin
        m_d--;
        if (m_d == 0) m_enter_acq();
      end else if (m_phase == P_ACQ && sample_valid) begin
        e.t = cyc + 2;
        e.v = {16'(mag(adc_d)), 16'(mag(adc_c)),
               16'(mag(adc_b)), 16'(mag(adc_a))};
        e.o = {fs(adc_d), fs(adc_c), fs(adc_b), fs(adc_a)};
        evq.push_back(e);
        m_n--;
        if (m_n == 0) begin
          m_phase   = P_FLUSH;
          m_done_at = cyc + 2;
        end
      end
      while (evq.size() > 0 && evq[0].t == cyc) begin
        e = evq.pop_front();
        for (int i = 0; i < 4; i++)
          if (int'(e.v[16*i +: 16]) > m_peak[i]) m_peak[i] = int'(e.v[16*i +: 16]);
        m_ovr |= e.o;
      end
      if (m_phase == P_FLUSH && cyc == m_done_at) begin
        m_phase = P_DONE;
        m_ready = 1;
        m_busy  = 0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("cyc_max_a", 32'(signal_max_a), m_peak[0]);
    chk("cyc_max_b", 32'(signal_max_b), m_peak[1]);
    chk("cyc_max_c", 32'(signal_max_c), m_peak[2]);
    chk("cyc_max_d", 32'(signal_max_d), m_peak[3]);
    chk("cyc_ready", 32'(ready), 32'(m_ready));
    chk("cyc_busy",  32'(busy),  32'(m_busy));
`ifdef PEAK_OVERRANGE_EN
    chk("cyc_ovr",   32'(overrange), 32'(m_ovr));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step(bit tr, bit v, int a, int b, int c, int d);
    trigger = tr;
    sample_valid = v;
    adc_a = AW'(a);
    adc_b = AW'(b);
    adc_c = AW'(c);
    adc_d = AW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int budget);
    int k = 0;
    while (!ready && k < budget) begin
      step(0, 0, 0, 0, 0, 0);
      k++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  initial begin
    int n;
    int sa[4];
    sa = '{100, -300, 200, 50};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_max_a", 32'(signal_max_a), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_busy",  32'(busy), 0);
    rst = 1'b0;

    // Basic window; count includes the cycle trigger is held
    trig_delay = 16'd0;
    win_len    = 16'd4;
    step(1, 0, 0, 0, 0, 0);
    n = 1;
    chk("basic_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, sa[i], i + 1, -(i * 7), 3);
      n++;
    end
    while (!ready && n < 20) begin
      step(0, 0, 0, 0, 0, 0);
      n++;
    end
    chk("basic_latency", n, 7);
    chk("basic_max_a", 32'(signal_max_a), 300);
    chk("basic_busy_off", 32'(busy), 0);

    // Delay: first sample coincides with trigger, next three skipped
    trig_delay = 16'd3;
    win_len    = 16'd2;
    step(1, 1, 9000, 0, 0, 0);
    step(0, 1, 9000, 0, 0, 0);
    chk("delay_hold_a", 32'(signal_max_a), 300);
    step(0, 1, 9000, 0, 0, 0);
    step(0, 1, 9000, 0, 0, 0);
    step(0, 1, 10, 0, 0, 0);
    step(0, 1, 20, 0, 0, 0);
    wait_ready(10);
    chk("delay_max_a", 32'(signal_max_a), 20);

    // Full-scale negative on channel B
    trig_delay = 16'd0;
    win_len    = 16'd1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 5, -8192, 100, -1);
    wait_ready(10);
    chk("fs_max_b", 32'(signal_max_b), 8192);
    chk("fs_max_d", 32'(signal_max_d), 1);
`ifdef PEAK_OVERRANGE_EN
    chk("fs_ovr", 32'(overrange), 32'b0010);
`endif

    // Gapped valid, ignored mid-ACQ trigger, re-arm from DONE
    trig_delay = 16'd0;
    win_len    = 16'd3;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 500, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    trig_delay = 16'd5;
    step(1, 1, 700, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 600, 0, 0, 0);
    wait_ready(10);
    chk("gap_max_a", 32'(signal_max_a), 700);
    trig_delay = 16'd2;
    win_len    = 16'd1;
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rearm_ready_hold", 32'(ready), 1);
    chk("rearm_max_hold", 32'(signal_max_a), 700);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("rearm_clear_a", 32'(signal_max_a), 0);
    chk("rearm_clear_ready", 32'(ready), 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 42, 0, 0, 0);
    wait_ready(10);
    chk("rearm_max_a", 32'(signal_max_a), 42);

    // Reset during ACQ, then a clean window
    trig_delay = 16'd0;
    win_len    = 16'd10;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1000, 1000, 1000, 1000);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("rstacq_max_a", 32'(signal_max_a), 0);
    chk("rstacq_max_d", 32'(signal_max_d), 0);
    chk("rstacq_busy", 32'(busy), 0);
    chk("rstacq_ready", 32'(ready), 0);
    trig_delay = 16'd1;
    win_len    = 16'd2;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 999, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    step(0, 1, -7, 0, 0, 0);
    wait_ready(10);
    chk("rstacq_next_a", 32'(signal_max_a), 7);

    // win_len 0 takes exactly one sample
    trig_delay = 16'd0;
    win_len    = 16'd0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 33, 0, 0, 0);
    step(0, 1, 99, 0, 0, 0);
    wait_ready(10);
    chk("win0_max_a", 32'(signal_max_a), 33);
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
